// File: rtl/state_sequencer_pkg.sv
// ============================================================================
// state_machines_pkg : shared codes for the ring FSM and its sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package state_machines_pkg;

  localparam logic [3:0] FSM_INIT  = 4'b0001;
  localparam logic [3:0] FSM_ONE   = 4'b0010;
  localparam logic [3:0] FSM_TWO   = 4'b0100;
  localparam logic [3:0] FSM_THREE = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DWELL    = 3'd1,
    S_STEP     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } seq_state_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_BAD_START  = 2'b01;
  localparam logic [1:0] ERR_ACK_TMO    = 2'b10;
  localparam logic [1:0] ERR_UNEXPECTED = 2'b11;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return FSM_INIT << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/state_sequencer_if.sv
// ============================================================================
// state_sequencer_if : host / ring-FSM signals of the state sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface state_sequencer_if #(
  parameter int CNT_W = 8
);
  logic               start;
  logic               stop;
  logic [4*CNT_W-1:0] dwell;
  logic [7:0]         loops;
  logic [3:0]         fsm_state;
  logic [3:0]         step;
  logic               busy;
  logic               done;
  logic               error;
  logic [1:0]         err_code;
  logic [1:0]         cur_idx;

  modport master (
    input  start, stop, dwell, loops, fsm_state,
    output step, busy, done, error, err_code, cur_idx
  );

  modport slave (
    output start, stop, dwell, loops, fsm_state,
    input  step, busy, done, error, err_code, cur_idx
  );
endinterface

`default_nettype wire

// File: rtl/state_sequencer_counter.sv
// ============================================================================
// seq_down_counter : loadable down counter, saturates at zero
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_down_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] value,
  input  wire logic             enable,
  output logic                  zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/state_sequencer.sv
// ============================================================================
// state_sequencer : steps the 4-state ring FSM with per-state dwell times
// Revision 1.0
// ============================================================================
`default_nettype none

module state_sequencer #(
  parameter int CNT_W   = 8,
  parameter int ACK_TMO = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  state_sequencer_if.master   bus
);
  import state_machines_pkg::*;

  seq_state_e         state_q, state_d;
  logic [1:0]         cur_idx_q, cur_idx_d;
  logic [7:0]         loop_q, loop_d;
  logic [4*CNT_W-1:0] dwell_q, dwell_d;
  logic [7:0]         loops_q, loops_d;
  logic               error_q, error_d;
  logic [1:0]         err_q, err_d;
  logic [3:0]         step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_en;
  logic               cnt_zero;

  // One counter times both the dwell and the acknowledge window.
  seq_down_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .value  (cnt_val),
    .enable (cnt_en),
    .zero   (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    loop_d    = loop_q;
    dwell_d   = dwell_q;
    loops_d   = loops_q;
    error_d   = error_q;
    err_d     = err_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_en    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          dwell_d   = bus.dwell;
          loops_d   = bus.loops;
          loop_d    = '0;
          cur_idx_d = 2'd0;
          error_d   = 1'b0;
          err_d     = ERR_NONE;
          if (bus.fsm_state == FSM_INIT) begin
            state_d  = S_DWELL;
            cnt_load = 1'b1;
            cnt_val  = bus.dwell[CNT_W-1:0];
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
            err_d   = ERR_BAD_START;
          end
        end
      end
      S_DWELL: begin
        if (bus.fsm_state != onehot4(cur_idx_q)) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          err_d   = ERR_UNEXPECTED;
        end else if (cnt_zero) begin
          state_d = S_STEP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_STEP: begin
        state_d  = S_WAIT_ACK;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(ACK_TMO - 1);
      end
      S_WAIT_ACK: begin
        if (bus.fsm_state == onehot4(cur_idx_q + 2'd1)) begin
          cur_idx_d = cur_idx_q + 2'd1;
          state_d   = S_DWELL;
          if (cur_idx_q == 2'd3) begin
            loop_d = loop_q + 8'd1;
            if ((loops_q != '0) && (loop_d == loops_q)) begin
              state_d = S_DONE;
            end
          end
          if (state_d == S_DWELL) begin
            cnt_load = 1'b1;
            cnt_val  = dwell_q[cur_idx_d*CNT_W +: CNT_W];
          end
        end else if (cnt_zero) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          err_d   = ERR_ACK_TMO;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition decided above, including errors.
    if (bus.stop && ((state_q == S_DWELL) || (state_q == S_STEP) ||
                     (state_q == S_WAIT_ACK))) begin
      state_d   = S_IDLE;
      cur_idx_d = cur_idx_q;
      loop_d    = loop_q;
      error_d   = error_q;
      err_d     = err_q;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
    end

    step_d = (state_d == S_STEP) ? onehot4(cur_idx_d) : 4'b0000;
    busy_d = (state_d == S_DWELL) || (state_d == S_STEP) || (state_d == S_WAIT_ACK);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_idx_q <= 2'd0;
      loop_q    <= '0;
      dwell_q   <= '0;
      loops_q   <= '0;
      error_q   <= 1'b0;
      err_q     <= ERR_NONE;
      step_q    <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      loop_q    <= loop_d;
      dwell_q   <= dwell_d;
      loops_q   <= loops_d;
      error_q   <= error_d;
      err_q     <= err_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.step     = step_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_q;
  assign bus.cur_idx  = cur_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_state_sequencer.sv
// ============================================================================
// tb_state_sequencer : drives the sequencer against a ring-FSM model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_state_sequencer;

  localparam int CNT_W = 8;
  localparam int K_STEP = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] val;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  sb[$];
  logic mon_en;

  state_sequencer_if #(.CNT_W(CNT_W)) bus ();

  state_sequencer #(.CNT_W(CNT_W), .ACK_TMO(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring FSM model: step registered into state_cur, then into state_outputs.
  logic [3:0] m_cur, m_out;
  logic       ignore0;
  logic       force_en;
  logic [3:0] force_val;

  always @(posedge clk) begin
    if (reset) begin
      m_cur <= 4'b0001;
      m_out <= 4'b0001;
    end else begin
      m_out <= m_cur;
      if (((bus.step & m_cur) != 4'b0000) && !(ignore0 && bus.step[0]))
        m_cur <= {m_cur[2:0], m_cur[3]};
    end
  end

  assign bus.fsm_state = force_en ? force_val : m_out;

  // Scoreboard monitor: every step, done pulse or error rising edge is an event.
  logic       err_prev;
  logic       have;
  logic [3:0] val;
  ev_t        e;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        have = 1'b0;
        val  = 4'b0000;
        case (k)
          K_STEP: if (bus.step != 4'b0000) begin have = 1'b1; val = bus.step; end
          K_DONE: if (bus.done) begin have = 1'b1; val = 4'b0001; end
          default: if (bus.error && !err_prev) begin have = 1'b1; val = {2'b00, bus.err_code}; end
        endcase
        if (have) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cycle=%0d val=%b, required no event",
                     k, cyc, val);
          end else begin
            e = sb.pop_front();
            if ((e.kind !== k) || (e.cyc !== cyc) || (e.val !== val)) begin
              errors++;
              $display("FAIL scoreboard: got kind=%0d cycle=%0d val=%b, required kind=%0d cycle=%0d val=%b",
                       k, cyc, val, e.kind, e.cyc, e.val);
            end
          end
        end
      end
    end
    err_prev = bus.error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int kind, input int c, input logic [3:0] v);
    ev_t x;
    x.kind = kind;
    x.cyc  = c;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic launch(input logic [4*CNT_W-1:0] dw, input logic [7:0] lp);
    bus.dwell = dw;
    bus.loops = lp;
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
    bus.dwell = '1;
    bus.loops = 8'd7;
  endtask

  task automatic run_until(input int last);
    while (cyc < last) tick();
  endtask

  task automatic test_drain(input string name);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d unseen events, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.step, bus.busy, bus.done, bus.error, bus.err_code, bus.cur_idx} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got step=%b busy=%b done=%b error=%b err=%b idx=%0d, required all 0",
               bus.step, bus.busy, bus.done, bus.error, bus.err_code, bus.cur_idx);
    end
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_single_rotation();
    push(K_STEP, 4, 4'b0001);
    push(K_STEP, 8, 4'b0010);
    push(K_STEP, 13, 4'b0100);
    push(K_STEP, 20, 4'b1000);
    push(K_DONE, 23, 4'b0001);
    launch({8'd3, 8'd1, 8'd0, 8'd2}, 8'd1);
    while (cyc < 26) begin
      checks++;
      if (bus.busy !== ((cyc >= 1) && (cyc <= 22))) begin
        errors++;
        $display("FAIL rot_busy: cycle %0d got %b, required %b", cyc, bus.busy,
                 (cyc >= 1) && (cyc <= 22));
      end
      if (cyc == 12) begin
        checks++;
        if (bus.cur_idx !== 2'd2) begin
          errors++;
          $display("FAIL rot_cur_idx: got %0d, required 2", bus.cur_idx);
        end
      end
      tick();
    end
    test_drain("rotation");
  endtask

  task automatic test_bad_start();
    force_val = 4'b0010;
    force_en  = 1'b1;
    push(K_ERR, 1, 4'b0001);
    launch('0, 8'd1);
    checks++;
    if ((bus.error !== 1'b1) || (bus.err_code !== 2'b01)) begin
      errors++;
      $display("FAIL bad_start: got error=%b code=%b, required 1/01", bus.error, bus.err_code);
    end
    run_until(6);
    force_en = 1'b0;
    test_drain("bad_start");
  endtask

  task automatic test_ack_timeout();
    ignore0 = 1'b1;
    push(K_STEP, 2, 4'b0001);
    push(K_ERR, 7, 4'b0010);
    launch('0, 8'd1);
    run_until(6);
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got error=%b at cycle 6, required 0", bus.error);
    end
    tick();
    checks++;
    if ((bus.err_code !== 2'b10) || (bus.busy !== 1'b0)) begin
      errors++;
      $display("FAIL tmo_code: got code=%b busy=%b, required 10/0", bus.err_code, bus.busy);
    end
    run_until(10);
    ignore0 = 1'b0;
    test_drain("timeout");
  endtask

  task automatic test_glitch();
    push(K_ERR, 4, 4'b0011);
    launch({8'd0, 8'd0, 8'd0, 8'd5}, 8'd1);
    run_until(3);
    force_val = 4'b0100;
    force_en  = 1'b1;
    tick();
    force_en = 1'b0;
    checks++;
    if ((bus.error !== 1'b1) || (bus.err_code !== 2'b11)) begin
      errors++;
      $display("FAIL glitch: got error=%b code=%b, required 1/11", bus.error, bus.err_code);
    end
    run_until(12);
    test_drain("glitch");
  endtask

  task automatic test_stop();
    push(K_STEP, 4, 4'b0001);
    launch({8'd2, 8'd2, 8'd2, 8'd2}, 8'd0);
    run_until(4);
    bus.stop = 1'b1;
    tick();
    checks++;
    if ((bus.step !== 4'b0000) || (bus.busy !== 1'b0)) begin
      errors++;
      $display("FAIL stop: got step=%b busy=%b, required 0000/0", bus.step, bus.busy);
    end
    run_until(12);
    bus.stop = 1'b0;
    test_drain("stop");
    // The FSM was left at ONE, so a restart must be refused.
    push(K_ERR, 1, 4'b0001);
    launch('0, 8'd1);
    run_until(4);
    test_drain("stop_restart");
  endtask

  task automatic test_reset_restart();
    push(K_STEP, 2, 4'b0001);
    launch('0, 8'd2);
    run_until(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.step, bus.busy, bus.done, bus.error, bus.err_code, bus.cur_idx} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset: got step=%b busy=%b done=%b error=%b err=%b idx=%0d, required all 0",
               bus.step, bus.busy, bus.done, bus.error, bus.err_code, bus.cur_idx);
    end
    tick();
    test_drain("reset");
    for (int i = 0; i < 8; i++) push(K_STEP, 2 + 4*i, 4'b0001 << (i % 4));
    push(K_DONE, 33, 4'b0001);
    launch('0, 8'd2);
    run_until(32);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy: got %b at cycle 32, required 1", bus.busy);
    end
    run_until(40);
    test_drain("restart");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    err_prev  = 1'b0;
    ignore0   = 1'b0;
    force_en  = 1'b0;
    force_val = 4'b0000;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dwell = '0;
    bus.loops = '0;
    test_reset();
    test_single_rotation();
    test_bad_start();
    test_ack_timeout();
    test_glitch();
    test_stop();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
